// File: rtl/pci_initiator.sv
// PCI bus-master front end: request/grant, address phase, data burst,
// turnaround, and master abort when no target claims the cycle.
module pci_initiator #(
  parameter int MAX_WORDS      = 8,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [3:0]  Cmd,
  input  logic [31:0] Addr,
  input  logic [3:0]  Num_Words,
  input  logic [31:0] Wr_Data,
  output logic        Wr_Pop,
  output logic [31:0] Rd_Data,
  output logic        Rd_Valid,
  output logic        Busy,
  output logic        Done,
  output logic        Abort,
  output logic        REQ_n,
  input  logic        GNT_n,
  input  logic        Bus_Idle,
  output logic        FRAME_n,
  output logic        IRDY_n,
  input  logic        TRDY_n,
  input  logic        DEVSEL_n,
  output logic [31:0] AD_Out,
  input  logic [31:0] AD_In,
  output logic        AD_OE,
  output logic [3:0]  CBE_n
);

  localparam logic [3:0] MAXW = 4'(MAX_WORDS);
  localparam logic [3:0] TMO  = 4'(DEVSEL_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_DATA, S_MABORT, S_TURN
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cmd, w_cmd;
  logic [31:0] r_addr, w_addr;
  logic [3:0]  r_cnt, w_cnt;
  logic [3:0]  r_tmr, w_tmr;
  logic        r_dsel, w_dsel;
  logic        r_abt, w_abt;
  logic [31:0] r_rd_data, w_rd_data;
  logic        r_rd_valid, w_rd_valid;
  logic        r_req_n, w_req_n;
  logic        r_frame_n, w_frame_n;
  logic        r_irdy_n, w_irdy_n;
  logic        r_ad_oe, w_ad_oe;
  logic [3:0]  r_cbe_n, w_cbe_n;
  logic [31:0] r_ad_out, w_ad_out;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_abort, w_abort;
  logic        w_xfer;
  logic        w_wr_data;

  assign w_xfer    = (r_state == S_DATA) & ~TRDY_n & ~DEVSEL_n;
  assign w_wr_data = (r_state == S_DATA) & r_cmd[0];

  assign Wr_Pop   = w_xfer & r_cmd[0];
  assign AD_Out   = w_wr_data ? Wr_Data : r_ad_out;
  assign Rd_Data  = r_rd_data;
  assign Rd_Valid = r_rd_valid;
  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Abort    = r_abort;
  assign REQ_n    = r_req_n;
  assign FRAME_n  = r_frame_n;
  assign IRDY_n   = r_irdy_n;
  assign AD_OE    = r_ad_oe;
  assign CBE_n    = r_cbe_n;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_dsel     <= 1'b0;
      r_abt      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_req_n    <= 1'b1;
      r_frame_n  <= 1'b1;
      r_irdy_n   <= 1'b1;
      r_ad_oe    <= 1'b0;
      r_cbe_n    <= 4'hF;
      r_ad_out   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cmd      <= w_cmd;
      r_addr     <= w_addr;
      r_cnt      <= w_cnt;
      r_tmr      <= w_tmr;
      r_dsel     <= w_dsel;
      r_abt      <= w_abt;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
      r_req_n    <= w_req_n;
      r_frame_n  <= w_frame_n;
      r_irdy_n   <= w_irdy_n;
      r_ad_oe    <= w_ad_oe;
      r_cbe_n    <= w_cbe_n;
      r_ad_out   <= w_ad_out;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_abort    <= w_abort;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cmd      = r_cmd;
    w_addr     = r_addr;
    w_cnt      = r_cnt;
    w_tmr      = r_tmr;
    w_dsel     = r_dsel;
    w_abt      = r_abt;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_cmd  = Cmd;
          w_addr = Addr;
          if (Num_Words == 4'd0)
            w_cnt = 4'd1;
          else if (Num_Words > MAXW)
            w_cnt = MAXW;
          else
            w_cnt = Num_Words;
          w_tmr  = '0;
          w_dsel = 1'b0;
          w_abt  = 1'b0;
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (!GNT_n && Bus_Idle)
          w_next = S_ADDR;
      end
      S_ADDR: w_next = S_DATA;
      S_DATA: begin
        if (!DEVSEL_n) begin
          w_dsel = 1'b1;
          w_tmr  = '0;
        end else if (!r_dsel) begin
          w_tmr = r_tmr + 4'd1;
          if (w_tmr == TMO)
            w_next = S_MABORT;
        end
        if (w_xfer) begin
          w_cnt = r_cnt - 4'd1;
          if (!r_cmd[0]) begin
            w_rd_data  = AD_In;
            w_rd_valid = 1'b1;
          end
          if (r_cnt == 4'd1)
            w_next = S_TURN;
        end
      end
      S_MABORT: begin
        w_abt  = 1'b1;
        w_next = S_TURN;
      end
      S_TURN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered bus outputs are decoded from the state being entered
  always_comb begin
    w_req_n   = 1'b1;
    w_frame_n = 1'b1;
    w_irdy_n  = 1'b1;
    w_ad_oe   = 1'b0;
    w_cbe_n   = 4'hF;
    w_ad_out  = r_ad_out;
    w_busy    = (w_next != S_IDLE);
    w_done    = 1'b0;
    w_abort   = 1'b0;
    unique case (w_next)
      S_REQ: w_req_n = 1'b0;
      S_ADDR: begin
        w_frame_n = 1'b0;
        w_ad_oe   = 1'b1;
        w_ad_out  = r_addr;
        w_cbe_n   = r_cmd;
      end
      S_DATA: begin
        w_irdy_n  = 1'b0;
        w_cbe_n   = 4'h0;
        w_ad_oe   = r_cmd[0];
        w_frame_n = (w_cnt == 4'd1);
      end
      S_MABORT: begin
        w_irdy_n = 1'b0;
        w_cbe_n  = 4'h0;
      end
      S_TURN: begin
        w_done  = ~w_abt;
        w_abort = w_abt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed and randomized bursts for pci_initiator, checked cycle by
// cycle against a transaction-level plan built inside the bench.
module tb_pci_initiator;

  localparam int MAXW = 8;
  localparam int TMO  = 5;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Cmd = '0;
  logic [31:0] Addr = '0;
  logic [3:0]  Num_Words = '0;
  logic [31:0] Wr_Data = '0;
  logic        Wr_Pop;
  logic [31:0] Rd_Data;
  logic        Rd_Valid;
  logic        Busy;
  logic        Done;
  logic        Abort;
  logic        REQ_n;
  logic        GNT_n = 1'b1;
  logic        Bus_Idle = 1'b1;
  logic        FRAME_n;
  logic        IRDY_n;
  logic        TRDY_n = 1'b1;
  logic        DEVSEL_n = 1'b1;
  logic [31:0] AD_Out;
  logic [31:0] AD_In = '0;
  logic        AD_OE;
  logic [3:0]  CBE_n;

  int checks = 0;
  int errors = 0;

  pci_initiator #(.MAX_WORDS(MAXW), .DEVSEL_TIMEOUT(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Cmd(Cmd), .Addr(Addr),
    .Num_Words(Num_Words), .Wr_Data(Wr_Data), .Wr_Pop(Wr_Pop),
    .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Busy(Busy), .Done(Done),
    .Abort(Abort), .REQ_n(REQ_n), .GNT_n(GNT_n), .Bus_Idle(Bus_Idle),
    .FRAME_n(FRAME_n), .IRDY_n(IRDY_n), .TRDY_n(TRDY_n),
    .DEVSEL_n(DEVSEL_n), .AD_Out(AD_Out), .AD_In(AD_In), .AD_OE(AD_OE),
    .CBE_n(CBE_n)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_words(input int n);
    if (n == 0) return 1;
    if (n > MAXW) return MAXW;
    return n;
  endfunction

  // Noise on inputs the DUT must ignore while busy
  task automatic rand_req_inputs();
    Start     = 1'($urandom_range(0, 1));
    Cmd       = 4'($urandom);
    Addr      = $urandom;
    Num_Words = 4'($urandom);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, REQ_n, 1);
    chk({tag, "_frame"}, FRAME_n, 1);
    chk({tag, "_irdy"}, IRDY_n, 1);
    chk({tag, "_adoe"}, AD_OE, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_wrpop"}, Wr_Pop, 0);
    chk({tag, "_rdv"}, Rd_Valid, 0);
    chk({tag, "_cbe"}, CBE_n, 4'hF);
    chk({tag, "_adout"}, AD_Out, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_abort"}, Abort, 0);
  endtask

  task automatic idle_cycle();
    @(negedge Clk);
    Start = 1'b0;
    GNT_n = 1'($urandom_range(0, 1));
    Bus_Idle = 1'b1;
    TRDY_n = 1'b1;
    DEVSEL_n = 1'b1;
    #1;
    chk("idle_busy", Busy, 0);
    chk("idle_req", REQ_n, 1);
    chk("idle_frame", FRAME_n, 1);
    chk("idle_done", Done, 0);
    chk("idle_abort", Abort, 0);
  endtask

  task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr,
                         input int nw, input int req_wait,
                         input bit gnt_busy, input int dsel_dly,
                         input bit no_target, input int wait_idx,
                         input int wait_len, input int rst_at);
    int k;
    int left;
    int nwt;
    bit wr;
    bit xfer;
    bit pend_rd;
    logic [31:0] pend_val;
    bit pdev[$];
    bit ptrdy[$];
    k = clamp_words(nw);
    wr = cmd[0];
    left = k;
    pend_rd = 1'b0;
    pend_val = '0;
    if (no_target) begin
      for (int c = 0; c < TMO; c++) begin
        pdev.push_back(1'b1);
        ptrdy.push_back(1'($urandom_range(0, 1)));
      end
    end else begin
      for (int c = 0; c < dsel_dly; c++) begin
        pdev.push_back(1'b1);
        ptrdy.push_back(1'b1);
      end
      for (int j = 0; j < k; j++) begin
        if (wait_len < 0) nwt = $urandom_range(0, 2);
        else nwt = (j == wait_idx) ? wait_len : 0;
        for (int c = 0; c < nwt; c++) begin
          pdev.push_back(1'b0);
          ptrdy.push_back(1'b1);
        end
        pdev.push_back(1'b0);
        ptrdy.push_back(1'b0);
      end
    end
    @(negedge Clk);
    Start = 1'b1;
    Cmd = cmd;
    Addr = addr;
    Num_Words = nw[3:0];
    GNT_n = 1'b1;
    Bus_Idle = 1'b1;
    TRDY_n = 1'b1;
    DEVSEL_n = 1'b1;
    #1;
    chk("start_busy", Busy, 0);
    for (int r = 0; r <= req_wait; r++) begin
      @(negedge Clk);
      rand_req_inputs();
      if (r == req_wait) begin
        GNT_n = 1'b0;
        Bus_Idle = 1'b1;
      end else if (gnt_busy) begin
        GNT_n = 1'b0;
        Bus_Idle = 1'b0;
      end else begin
        GNT_n = 1'b1;
        Bus_Idle = 1'($urandom_range(0, 1));
      end
      #1;
      chk("req_req", REQ_n, 0);
      chk("req_frame", FRAME_n, 1);
      chk("req_busy", Busy, 1);
      chk("req_adoe", AD_OE, 0);
    end
    @(negedge Clk);
    rand_req_inputs();
    GNT_n = 1'($urandom_range(0, 1));
    Bus_Idle = 1'($urandom_range(0, 1));
    #1;
    chk("addr_frame", FRAME_n, 0);
    chk("addr_irdy", IRDY_n, 1);
    chk("addr_req", REQ_n, 1);
    chk("addr_adoe", AD_OE, 1);
    chk("addr_ad", AD_Out, addr);
    chk("addr_cbe", CBE_n, cmd);
    for (int c = 0; c < pdev.size(); c++) begin
      @(negedge Clk);
      rand_req_inputs();
      GNT_n = 1'($urandom_range(0, 1));
      Bus_Idle = 1'($urandom_range(0, 1));
      DEVSEL_n = pdev[c];
      TRDY_n = ptrdy[c];
      Wr_Data = $urandom;
      AD_In = $urandom;
      #1;
      if (c == rst_at) begin
        Start = 1'b0;
        Rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge Clk);
        Rst_n = 1'b1;
        return;
      end
      xfer = !TRDY_n && !DEVSEL_n;
      chk("data_irdy", IRDY_n, 0);
      chk("data_cbe", CBE_n, 4'h0);
      chk("data_frame", FRAME_n, (left == 1));
      chk("data_adoe", AD_OE, wr);
      if (wr) chk("data_wdata", AD_Out, Wr_Data);
      chk("data_wrpop", Wr_Pop, wr && xfer);
      chk("data_rdv", Rd_Valid, pend_rd);
      if (pend_rd) chk("data_rdata", Rd_Data, pend_val);
      chk("data_done", Done, 0);
      chk("data_abort", Abort, 0);
      pend_rd = xfer && !wr;
      pend_val = AD_In;
      if (xfer) left--;
    end
    chk("words_left", left, no_target ? k : 0);
    if (no_target) begin
      @(negedge Clk);
      rand_req_inputs();
      TRDY_n = 1'b0;
      DEVSEL_n = 1'b0;
      #1;
      chk("mab_frame", FRAME_n, 1);
      chk("mab_irdy", IRDY_n, 0);
      chk("mab_rdv", Rd_Valid, 0);
      chk("mab_wrpop", Wr_Pop, 0);
      chk("mab_done", Done, 0);
    end
    @(negedge Clk);
    Start = 1'b1;
    TRDY_n = 1'b0;
    DEVSEL_n = 1'b0;
    #1;
    chk("turn_frame", FRAME_n, 1);
    chk("turn_irdy", IRDY_n, 1);
    chk("turn_adoe", AD_OE, 0);
    chk("turn_cbe", CBE_n, 4'hF);
    chk("turn_done", Done, !no_target);
    chk("turn_abort", Abort, no_target);
    chk("turn_wrpop", Wr_Pop, 0);
    chk("turn_rdv", Rd_Valid, pend_rd);
    if (pend_rd) chk("turn_rdata", Rd_Data, pend_val);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    #1;
    chk_reset_outs("reset");
    chk("reset_rdata", Rd_Data, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    idle_cycle();

    run_txn(4'b0111, 32'h1000, 1, 1, 1'b0, 0, 1'b0, -1, 0, -1);
    idle_cycle();
    idle_cycle();
    run_txn(4'b0110, 32'h2000_0040, 4, 0, 1'b0, 0, 1'b0, 1, 2, -1);
    idle_cycle();
    run_txn(4'b0110, 32'h3000_0000, 4, 0, 1'b0, 0, 1'b1, -1, 0, -1);
    idle_cycle();
    run_txn(4'b0111, 32'h4000_0010, 2, 3, 1'b1, 1, 1'b0, -1, -1, -1);
    idle_cycle();
    run_txn(4'b0111, 32'h5000_0000, 8, 0, 1'b0, 0, 1'b0, -1, 0, 2);
    idle_cycle();
    run_txn(4'b0110, 32'h6000_0000, 0, 0, 1'b0, 0, 1'b0, -1, 0, -1);
    idle_cycle();
    run_txn(4'b0111, 32'h7000_0000, 15, 0, 1'b0, 0, 1'b0, -1, -1, -1);
    idle_cycle();
    idle_cycle();

    for (int t = 0; t < 25; t++) begin
      run_txn($urandom_range(0, 1) ? 4'b0111 : 4'b0110, $urandom,
              $urandom_range(0, 15), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0), -1, -1, -1);
      idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
